// File: rtl/fir_result_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fir_result_sink                                            |
// | Description : Output-side companion to the serial FIR engine. Rounds     |
// |               (half-up) and saturates the wide signed FIR result to the  |
// |               sample width, buffers it in a first-word-fall-through FIFO |
// |               and presents it on a valid/ready stream. Pushes into a     |
// |               full FIFO are dropped, flagged and counted.                |
// | Option      : FIR_SINK_SAT_CNT_EN adds sat_cnt_o, a saturating count of  |
// |               clipped samples.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fir_result_sink #(
   parameter int IN_W  = 27,
   parameter int OUT_W = 16,
   parameter int SHIFT = 11,
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       valid_i,
   input  logic signed [IN_W-1:0]     data_i,
   output logic                       m_valid_o,
   input  logic                       m_ready_i,
   output logic signed [OUT_W-1:0]    m_data_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_cnt_o
`ifdef FIR_SINK_SAT_CNT_EN
   ,
   output logic [15:0]                sat_cnt_o
`endif
);

   localparam int QW = IN_W + 1;
   localparam int AW = $clog2(DEPTH);

   localparam logic signed [QW-1:0] c_RND    = QW'(2 ** (SHIFT - 1));
   localparam logic signed [QW-1:0] c_MAX    = QW'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [QW-1:0] c_MIN    = ~c_MAX;
   localparam logic [AW:0]          c_FULL   = (AW + 1)'(DEPTH);
   localparam logic [15:0]          c_CNT_MAX = 16'hFFFF;

   // ---------------- stage 1: round and saturate ----------------
   logic signed [QW-1:0]    w_ext;
   logic signed [QW-1:0]    w_tmp;
   logic signed [QW-1:0]    w_q;
   logic                    w_clip_hi;
   logic                    w_clip_lo;
   logic signed [OUT_W-1:0] w_sat;

   logic                    r_s1_valid;
   logic signed [OUT_W-1:0] r_s1_data;

   // One extra bit of headroom so adding the rounding constant cannot wrap.
   assign w_ext     = $signed({data_i[IN_W-1], data_i});
   assign w_tmp     = w_ext + c_RND;
   assign w_q       = w_tmp >>> SHIFT;
   assign w_clip_hi = (w_q > c_MAX);
   assign w_clip_lo = (w_q < c_MIN);

   // Clamp the shifted value into the output sample range.
   always_comb begin
      w_sat = w_q[OUT_W-1:0];
      if (w_clip_hi) begin
         w_sat = c_MAX[OUT_W-1:0];
      end else if (w_clip_lo) begin
         w_sat = c_MIN[OUT_W-1:0];
      end
   end

   // Capture the rounded sample on each input strobe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= valid_i;
         if (valid_i) begin
            r_s1_data <= w_sat;
         end
      end
   end

   // ---------------- stage 2: FIFO ----------------
   logic signed [OUT_W-1:0] r_mem [DEPTH];
   logic [AW:0]             r_wr_ptr;
   logic [AW:0]             r_rd_ptr;
   logic                    r_overflow;
   logic [15:0]             r_drop_cnt;

   logic [AW:0]             w_level;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;

   // Pointers carry one extra wrap bit so full and empty stay distinct.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == c_FULL);
   assign w_pop   = !w_empty && m_ready_i;
   // A concurrent pop frees the slot, so a push at full still lands.
   assign w_push  = r_s1_valid && (!w_full || w_pop);
   assign w_drop  = r_s1_valid && w_full && !w_pop;

   // Sample storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= r_s1_data;
      end
   end

   // Pointer update and drop bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_CNT_MAX) begin
               r_drop_cnt <= r_drop_cnt + 16'd1;
            end
         end
      end
   end

   assign m_valid_o  = !w_empty;
   assign m_data_o   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign level_o    = w_level;
   assign overflow_o = r_overflow;
   assign drop_cnt_o = r_drop_cnt;

`ifdef FIR_SINK_SAT_CNT_EN
   logic [15:0] r_sat_cnt;

   // Count every clipped strobe, whether or not the FIFO later keeps it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sat_cnt <= '0;
      end else if (valid_i && (w_clip_hi || w_clip_lo) && (r_sat_cnt != c_CNT_MAX)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign sat_cnt_o = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_result_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fir_result_sink                                         |
// | Description : Directed self-checking bench for fir_result_sink.          |
// | Option      : FIR_SINK_SAT_CNT_EN enables the sat_cnt_o checks.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fir_result_sink;

   logic               clk_i;
   logic               rst_i;
   logic               valid_i;
   logic signed [26:0] data_i;
   logic               m_valid_o;
   logic               m_ready_i;
   logic signed [15:0] m_data_o;
   logic [3:0]         level_o;
   logic               overflow_o;
   logic [15:0]        drop_cnt_o;
`ifdef FIR_SINK_SAT_CNT_EN
   logic [15:0]        sat_cnt_o;
`endif

   int n_pass;
   int n_total;

   fir_result_sink #(
      .IN_W  (27),
      .OUT_W (16),
      .SHIFT (11),
      .DEPTH (8)
   ) u_dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_data_o   (m_data_o),
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .drop_cnt_o (drop_cnt_o)
`ifdef FIR_SINK_SAT_CNT_EN
      ,
      .sat_cnt_o  (sat_cnt_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance one clock; inputs are driven and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      valid_i   = 1'b0;
      m_ready_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   // One-cycle strobe; returns 1 ns after the strobe edge.
   task automatic strobe(input logic signed [26:0] d);
      valid_i = 1'b1;
      data_i  = d;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i     = 1'b1;
      valid_i   = 1'b0;
      m_ready_i = 1'b0;
      data_i    = '0;
      tick();
      n_total++;
      if ({m_valid_o, m_data_o, level_o, overflow_o, drop_cnt_o} !== 38'd0)
         $display("FAIL reset_state: got v=%0b d=%0d lvl=%0d ov=%0b drop=%0d want all 0",
                  m_valid_o, m_data_o, level_o, overflow_o, drop_cnt_o);
      else n_pass++;
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_rounding();
      logic signed [26:0] din  [5];
      logic signed [15:0] dexp [5];
      din  = '{27'sd2048, 27'sd1023, 27'sd1024, -27'sd1024, -27'sd1025};
      dexp = '{16'sd1, 16'sd0, 16'sd1, 16'sd0, -16'sd1};
      do_reset();
      for (int i = 0; i < 5; i++) strobe(din[i]);
      tick();
      n_total++;
      if (level_o !== 4'd5) $display("FAIL round_level: got %0d want 5", level_o);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_total++;
         if (m_valid_o !== 1'b1 || m_data_o !== dexp[i])
            $display("FAIL round_%0d: got v=%0b d=%0d want v=1 d=%0d", i, m_valid_o, m_data_o, dexp[i]);
         else n_pass++;
         m_ready_i = 1'b1;
         tick();
         m_ready_i = 1'b0;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      strobe(27'sd67108863);
      strobe(-27'sd67108864);
      tick();
      n_total++;
      if (m_data_o !== 16'sd32767) $display("FAIL sat_pos: got %0d want 32767", m_data_o);
      else n_pass++;
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      n_total++;
      if (m_data_o !== -16'sd32768) $display("FAIL sat_neg: got %0d want -32768", m_data_o);
      else n_pass++;
`ifdef FIR_SINK_SAT_CNT_EN
      n_total++;
      if (sat_cnt_o !== 16'd1) $display("FAIL sat_cnt: got %0d want 1", sat_cnt_o);
      else n_pass++;
`endif
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
   endtask

   task automatic test_pacing();
      int vcount;
      int vpos;
      int lmax;
      do_reset();
      m_ready_i = 1'b1;
      lmax = 0;
      for (int s = 1; s <= 4; s++) begin
         strobe(27'(s * 4096));
         vcount = 0;
         vpos   = -1;
         for (int c = 0; c < 16; c++) begin
            if (m_valid_o === 1'b1) begin
               vcount++;
               vpos = c;
               n_total++;
               if (m_data_o !== 16'(2 * s)) $display("FAIL pace_data_%0d: got %0d want %0d", s, m_data_o, 2 * s);
               else n_pass++;
            end
            if (int'(level_o) > lmax) lmax = int'(level_o);
            if (c < 15) tick();
            else begin
               valid_i = 1'b1;
               data_i  = 27'((s + 1) * 4096);
               valid_i = 1'b0;
            end
         end
         n_total++;
         if (vcount != 1 || vpos != 1)
            $display("FAIL pace_pulse_%0d: got count=%0d pos=%0d want count=1 pos=1", s, vcount, vpos);
         else n_pass++;
      end
      n_total++;
      if (lmax > 1) $display("FAIL pace_level: got max %0d want <=1", lmax);
      else n_pass++;
      m_ready_i = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 1; k <= 10; k++) strobe(27'(k * 2048));
      tick();
      n_total++;
      if (level_o !== 4'd8 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2)
         $display("FAIL ovf_state: got lvl=%0d ov=%0b drop=%0d want lvl=8 ov=1 drop=2",
                  level_o, overflow_o, drop_cnt_o);
      else n_pass++;
      m_ready_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         n_total++;
         if (m_valid_o !== 1'b1 || m_data_o !== 16'(k))
            $display("FAIL drain_%0d: got v=%0b d=%0d want v=1 d=%0d", k, m_valid_o, m_data_o, k);
         else n_pass++;
         tick();
      end
      m_ready_i = 1'b0;
      n_total++;
      if (m_valid_o !== 1'b0 || level_o !== 4'd0 || overflow_o !== 1'b1)
         $display("FAIL drain_end: got v=%0b lvl=%0d ov=%0b want v=0 lvl=0 ov=1", m_valid_o, level_o, overflow_o);
      else n_pass++;
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int k = 1; k <= 8; k++) strobe(27'(k * 2048));
      tick();
      strobe(27'sd20480);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      n_total++;
      if (level_o !== 4'd8 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0 || m_data_o !== 16'sd2)
         $display("FAIL full_pop: got lvl=%0d drop=%0d ov=%0b head=%0d want lvl=8 drop=0 ov=0 head=2",
                  level_o, drop_cnt_o, overflow_o, m_data_o);
      else n_pass++;
      m_ready_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      n_total++;
      if (m_data_o !== 16'sd10 || level_o !== 4'd1)
         $display("FAIL full_pop_tail: got d=%0d lvl=%0d want d=10 lvl=1", m_data_o, level_o);
      else n_pass++;
      tick();
      m_ready_i = 1'b0;
   endtask

   task automatic test_level1_pop();
      do_reset();
      strobe(27'sd6144);
      tick();
      strobe(27'sd8192);
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      n_total++;
      if (level_o !== 4'd1 || m_data_o !== 16'sd4)
         $display("FAIL lvl1_pop: got lvl=%0d d=%0d want lvl=1 d=4", level_o, m_data_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 1; k <= 10; k++) strobe(27'(k * 2048));
      tick();
      m_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      m_ready_i = 1'b0;
      n_total++;
      if (level_o !== 4'd5 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2)
         $display("FAIL pre_rst: got lvl=%0d ov=%0b drop=%0d want lvl=5 ov=1 drop=2", level_o, overflow_o, drop_cnt_o);
      else n_pass++;
      #2 rst_i = 1'b1;
      #1;
      n_total++;
      if (m_valid_o !== 1'b0 || level_o !== 4'd0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0)
         $display("FAIL async_rst: got v=%0b lvl=%0d ov=%0b drop=%0d want all 0",
                  m_valid_o, level_o, overflow_o, drop_cnt_o);
      else n_pass++;
      tick();
      rst_i = 1'b0;
      strobe(27'sd6144);
      n_total++;
      if (m_valid_o !== 1'b0) $display("FAIL post_rst_early: got v=%0b want 0", m_valid_o);
      else n_pass++;
      tick();
      n_total++;
      if (m_valid_o !== 1'b1 || m_data_o !== 16'sd3 || level_o !== 4'd1)
         $display("FAIL post_rst: got v=%0b d=%0d lvl=%0d want v=1 d=3 lvl=1", m_valid_o, m_data_o, level_o);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_rounding();
      test_saturation();
      test_pacing();
      test_overflow();
      test_full_pop();
      test_level1_pop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
